control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle sequencer for the 16-bit CPU. It steps each instruction through fetch, decode, register read, ALU, optional memory access and writeback. It issues one-hot stage enables to the fetch path, decoder, register file, ALU and PC, and drives the register-file write strobe. It sits directly upstream of the register file and gates its enable and write.

## Interface
- MEM_TIMEOUT, 255: maximum wait cycles on a memory handshake before faulting. Range 1–255; the counter is 8 bits.
- I_clk  in  1  clock, all state changes on the rising edge
- I_reset_n  in  1  asynchronous, active-low reset
- I_mem_ready  in  1  memory completes the current request this cycle
- I_halt  in  1  decoder: current instruction is HALT
- I_is_mem  in  1  decoder: instruction is a load or store
- I_is_store  in  1  decoder: instruction is a store
- I_writes_rd  in  1  decoder: instruction writes rD
- I_branch_taken  in  1  ALU: branch condition true
- O_en_fetch  out  1  instruction-fetch enable
- O_en_decode  out  1  decoder enable
- O_en_reg  out  1  register-file enable
- O_reg_write  out  1  register-file write strobe
- O_en_alu  out  1  ALU enable
- O_mem_req  out  1  memory request, held until I_mem_ready
- O_mem_we  out  1  memory write (stores only)
- O_en_pc  out  1  PC update enable
- O_pc_op  out  2  PC operation: 00 hold, 01 increment, 10 load branch target
- O_halted  out  1  sequencer stopped on HALT
- O_fault  out  1  memory timeout; sticky until reset

## Operation
- States: IDLE, FETCH, DECODE, REG_READ, ALU, MEM, WRITEBACK, HALT, FAULT.
- All outputs are registered. Each output is a function of the next state, so it is valid for the whole cycle the FSM spends in that state.
- Reset:
  - State goes to IDLE.
  - Every output resets to 0, and O_pc_op resets to 00.
  - The timeout counter resets to 0.
- IDLE: no outputs asserted; always goes to FETCH.
- FETCH:
  - O_en_fetch=1, O_mem_req=1.
  - Stays in FETCH until I_mem_ready=1, then goes to DECODE.
- DECODE:
  - O_en_decode=1.
  - If I_halt, go to HALT; otherwise go to REG_READ.
- REG_READ: O_en_reg=1, O_reg_write=0. Register operands are valid on the following cycle.
- ALU:
  - O_en_alu=1.
  - If I_is_mem, go to MEM; otherwise go to WRITEBACK.
- MEM:
  - O_mem_req=1, O_mem_we=I_is_store.
  - Stays in MEM until I_mem_ready=1, then goes to WRITEBACK.
- WRITEBACK:
  - O_en_reg=1, O_reg_write=I_writes_rd and not I_is_store.
  - O_en_pc=1, O_pc_op=10 if I_branch_taken, else 01.
  - Always goes to FETCH.
- HALT: O_halted=1, all enables 0. Terminal state; only reset leaves it.
- FAULT: O_fault=1, all enables 0. O_mem_req drops on entry. Terminal state; only reset leaves it.
- Decoder flag inputs must be stable from DECODE through WRITEBACK. The block samples them only in the states listed above.
- At most one of O_en_fetch, O_en_decode, O_en_reg, O_en_alu and O_en_pc is high in any cycle, except that O_en_reg and O_en_pc are both high in WRITEBACK.

## Timing
- Non-memory instruction with zero-wait memory: 5 cycles (FETCH through WRITEBACK).
- Load or store with zero-wait memory: 6 cycles.
- Each cycle of I_mem_ready=0 adds one cycle.
- The first FETCH begins exactly 1 cycle after reset release, because IDLE lasts one cycle.
- The register-file write commits at the rising edge that ends WRITEBACK.
- Reset asserted mid-instruction aborts the instruction at once, and all outputs go to 0 asynchronously. No partial write is issued.
- I_mem_ready high outside FETCH or MEM is ignored.

## Configuration
- CTRL_MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to FETCH or MEM and increments each cycle the block waits there with I_mem_ready=0.
  - When the counter reaches MEM_TIMEOUT without ready, the next state is FAULT.
  - If I_mem_ready=1 in the same cycle the counter reaches the limit, ready wins and the FSM proceeds normally.
- Undefined: the block waits indefinitely, the FAULT state is unreachable, and O_fault is constant 0. The port still exists.

## Structure
- Package cpu_ctrl_pkg holds:
  - the state encoding (4-bit localparams, IDLE=0 … FAULT=8);
  - the O_pc_op codes (PC_HOLD=00, PC_INC=01, PC_BRANCH=10).
- One sub-module: ctrl_timeout_counter. It has clear, count and limit inputs and a hit output, and is instantiated only under CTRL_MEM_TIMEOUT_EN.

## Test plan
- Reset release, I_mem_ready=1, I_writes_rd=1, flags otherwise 0:
  - states IDLE, FETCH, DECODE, REG_READ, ALU, WRITEBACK;
  - O_reg_write=1 only on cycle 6 after release;
  - O_pc_op=01 in that cycle; next cycle is FETCH.
- Load (I_is_mem=1, I_is_store=0, I_writes_rd=1), I_mem_ready low for 3 cycles in MEM:
  - MEM lasts 4 cycles with O_mem_req=1 and O_mem_we=0;
  - WRITEBACK follows with O_reg_write=1.
- Store (I_is_mem=1, I_is_store=1, I_writes_rd=1): O_mem_we=1 in MEM, O_reg_write=0 in WRITEBACK.
- I_branch_taken=1: O_pc_op=10 in WRITEBACK. I_halt=1 in DECODE: HALT with O_halted=1, held for 20 cycles, and no enable ever rises.
- CTRL_MEM_TIMEOUT_EN, MEM_TIMEOUT=4:
  - I_mem_ready stuck 0 in FETCH gives FAULT after 4 wait cycles, with O_fault=1 and O_mem_req=0.
  - Ready on exactly the 4th wait cycle gives DECODE instead.
- Reset pulsed during MEM:
  - all outputs go to 0 immediately;
  - FETCH restarts 1 cycle after release;
  - O_fault clears.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: FSM states and PC operation codes.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StFetch     = 4'd1,
    StDecode    = 4'd2,
    StRegRead   = 4'd3,
    StAlu       = 4'd4,
    StMem       = 4'd5,
    StWriteback = 4'd6,
    StHalt      = 4'd7,
    StFault     = 4'd8
  } state_e;

  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  localparam int unsigned CntWidth = 8;

  // States in which the sequencer waits on a memory handshake.
  function automatic logic is_mem_wait(state_e s);
    return (s == StFetch) || (s == StMem);
  endfunction

endpackage

// File: rtl/ctrl_timeout_counter.sv
// Memory-handshake wait counter; hit flags the wait cycle on which the count reaches limit.
module ctrl_timeout_counter
  import cpu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                count,
  input  logic [CntWidth-1:0] limit,
  output logic                hit
);

  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth:0]   cnt_next;

  assign cnt_next = {1'b0, cnt_q} + {{CntWidth{1'b0}}, 1'b1};
  assign hit      = count && (cnt_next == {1'b0, limit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_q <= cnt_next[CntWidth-1:0];
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer with registered one-hot stage enables.
// Define CTRL_MEM_TIMEOUT_EN to fault on memory handshakes that exceed MEM_TIMEOUT wait cycles.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       I_clk,
  input  logic       I_reset_n,
  input  logic       I_mem_ready,
  input  logic       I_halt,
  input  logic       I_is_mem,
  input  logic       I_is_store,
  input  logic       I_writes_rd,
  input  logic       I_branch_taken,
  output logic       O_en_fetch,
  output logic       O_en_decode,
  output logic       O_en_reg,
  output logic       O_reg_write,
  output logic       O_en_alu,
  output logic       O_mem_req,
  output logic       O_mem_we,
  output logic       O_en_pc,
  output logic [1:0] O_pc_op,
  output logic       O_halted,
  output logic       O_fault
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be in 1..255");
  end

  state_e state_q, state_d;
  logic   timeout_hit;

`ifdef CTRL_MEM_TIMEOUT_EN
  logic wait_count;
  logic wait_clear;

  // Cleared whenever outside a wait state, so every FETCH/MEM entry starts from zero.
  assign wait_clear = !is_mem_wait(state_q);
  assign wait_count = is_mem_wait(state_q) && !I_mem_ready;

  ctrl_timeout_counter u_timeout (
    .clk   (I_clk),
    .rst_n (I_reset_n),
    .clear (wait_clear),
    .count (wait_count),
    .limit (CntWidth'(MEM_TIMEOUT)),
    .hit   (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      state_d = StFetch;
      StFetch: begin
        if (I_mem_ready)      state_d = StDecode;
        else if (timeout_hit) state_d = StFault;
      end
      StDecode:    state_d = I_halt ? StHalt : StRegRead;
      StRegRead:   state_d = StAlu;
      StAlu:       state_d = I_is_mem ? StMem : StWriteback;
      StMem: begin
        if (I_mem_ready)      state_d = StWriteback;
        else if (timeout_hit) state_d = StFault;
      end
      StWriteback: state_d = StFetch;
      StHalt:      state_d = StHalt;
      StFault:     state_d = StFault;
      default:     state_d = StIdle;
    endcase
  end

  // Outputs decode the next state so they are valid for the whole cycle spent in it.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q     <= StIdle;
      O_en_fetch  <= 1'b0;
      O_en_decode <= 1'b0;
      O_en_reg    <= 1'b0;
      O_reg_write <= 1'b0;
      O_en_alu    <= 1'b0;
      O_mem_req   <= 1'b0;
      O_mem_we    <= 1'b0;
      O_en_pc     <= 1'b0;
      O_pc_op     <= PC_HOLD;
      O_halted    <= 1'b0;
      O_fault     <= 1'b0;
    end else begin
      state_q     <= state_d;
      O_en_fetch  <= (state_d == StFetch);
      O_en_decode <= (state_d == StDecode);
      O_en_reg    <= (state_d == StRegRead) || (state_d == StWriteback);
      O_reg_write <= (state_d == StWriteback) && I_writes_rd && !I_is_store;
      O_en_alu    <= (state_d == StAlu);
      O_mem_req   <= is_mem_wait(state_d);
      O_mem_we    <= (state_d == StMem) && I_is_store;
      O_en_pc     <= (state_d == StWriteback);
      O_pc_op     <= (state_d != StWriteback) ? PC_HOLD :
                     (I_branch_taken ? PC_BRANCH : PC_INC);
      O_halted    <= (state_d == StHalt);
      O_fault     <= (state_d == StFault);
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table of instructions plus reset, halt and timeout sequences.
module tb_control_unit;

  localparam int unsigned Timeout = 4;

  // Output vector layout: fetch, decode, reg, reg_write, alu, mem_req, mem_we, en_pc, pc_op[1:0],
  // halted, fault.
  localparam logic [11:0] VZero  = 12'h000;
  localparam logic [11:0] VFetch = 12'h840;
  localparam logic [11:0] VDec   = 12'h400;
  localparam logic [11:0] VReg   = 12'h200;
  localparam logic [11:0] VAlu   = 12'h080;
  localparam logic [11:0] VHalt  = 12'h002;
  localparam logic [11:0] VFault = 12'h001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mem_ready = 1'b0;
  logic       halt = 1'b0;
  logic       is_mem = 1'b0;
  logic       is_store = 1'b0;
  logic       writes_rd = 1'b0;
  logic       branch_taken = 1'b0;
  logic       en_fetch, en_decode, en_reg, reg_write, en_alu, mem_req, mem_we, en_pc;
  logic [1:0] pc_op;
  logic       halted, fault;

  always #5 clk = ~clk;

  control_unit #(.MEM_TIMEOUT(Timeout)) dut (
    .I_clk          (clk),
    .I_reset_n      (rst_n),
    .I_mem_ready    (mem_ready),
    .I_halt         (halt),
    .I_is_mem       (is_mem),
    .I_is_store     (is_store),
    .I_writes_rd    (writes_rd),
    .I_branch_taken (branch_taken),
    .O_en_fetch     (en_fetch),
    .O_en_decode    (en_decode),
    .O_en_reg       (en_reg),
    .O_reg_write    (reg_write),
    .O_en_alu       (en_alu),
    .O_mem_req      (mem_req),
    .O_mem_we       (mem_we),
    .O_en_pc        (en_pc),
    .O_pc_op        (pc_op),
    .O_halted       (halted),
    .O_fault        (fault)
  );

  typedef struct {
    string       name;
    logic        is_mem;
    logic        is_store;
    logic        writes_rd;
    logic        branch;
    int unsigned wf;
    int unsigned wm;
    logic        exp_we;
    logic        exp_wr;
    logic [1:0]  exp_pc;
  } rec_t;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  rec_t tbl[7];

  function automatic logic [11:0] act_vec();
    return {en_fetch, en_decode, en_reg, reg_write, en_alu, mem_req, mem_we, en_pc, pc_op,
            halted, fault};
  endfunction

  function automatic logic [11:0] mem_vec(input logic we);
    return we ? 12'h060 : 12'h040;
  endfunction

  function automatic logic [11:0] wb_vec(input logic wr, input logic [1:0] pc);
    return 12'h210 | (wr ? 12'h100 : 12'h000) | {8'h00, pc, 2'b00};
  endfunction

  function automatic rec_t mk(input string n, input logic m, input logic s, input logic w,
                              input logic b, input int unsigned wf, input int unsigned wm,
                              input logic ewe, input logic ewr, input logic [1:0] epc);
    rec_t r;
    r.name = n; r.is_mem = m; r.is_store = s; r.writes_rd = w; r.branch = b;
    r.wf = wf; r.wm = wm; r.exp_we = ewe; r.exp_wr = ewr; r.exp_pc = epc;
    return r;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %03h want %03h", name, act, exp);
    end
  endtask

  // Drive ready for the coming edge, queue the expected vector, then compare after the edge.
  task automatic cyc(input logic ready, input logic [11:0] exp, input string name);
    mem_ready = ready;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(name, act_vec(), exp_q.pop_front());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", act_vec(), VZero);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input rec_t r);
    halt = 1'b0;
    is_mem = r.is_mem;
    is_store = r.is_store;
    writes_rd = r.writes_rd;
    branch_taken = r.branch;
    cyc(1'b1, VFetch, {r.name, "_fetch"});
    repeat (r.wf) cyc(1'b0, VFetch, {r.name, "_fetch_wait"});
    cyc(1'b1, VDec, {r.name, "_decode"});
    cyc(1'b1, VReg, {r.name, "_regread"});
    cyc(1'b1, VAlu, {r.name, "_alu"});
    if (r.is_mem) begin
      cyc(1'b1, mem_vec(r.exp_we), {r.name, "_mem"});
      repeat (r.wm) cyc(1'b0, mem_vec(r.exp_we), {r.name, "_mem_wait"});
    end
    cyc(1'b1, wb_vec(r.exp_wr, r.exp_pc), {r.name, "_writeback"});
  endtask

  initial begin
    tbl[0] = mk("alu_wr",    1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 2'b01);
    tbl[1] = mk("load_wait", 1'b1, 1'b0, 1'b1, 1'b0, 0, 3, 1'b0, 1'b1, 2'b01);
    tbl[2] = mk("store",     1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 2'b01);
    tbl[3] = mk("branch",    1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 2'b10);
    tbl[4] = mk("fetch_wt",  1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 2'b01);
    tbl[5] = mk("store_br",  1'b1, 1'b1, 1'b0, 1'b1, 1, 2, 1'b1, 1'b0, 2'b10);
    tbl[6] = mk("load_nowr", 1'b1, 1'b0, 1'b0, 1'b0, 3, 1, 1'b0, 1'b0, 2'b01);

    #2;
    do_reset();
    for (int i = 0; i < 7; i++) run_instr(tbl[i]);

    // HALT is terminal: nothing but O_halted for 20 cycles whatever the inputs do.
    halt = 1'b1; is_mem = 1'b0; is_store = 1'b0; writes_rd = 1'b1; branch_taken = 1'b0;
    cyc(1'b1, VFetch, "halt_fetch");
    cyc(1'b1, VDec, "halt_decode");
    cyc(1'b1, VHalt, "halt_enter");
    for (int i = 0; i < 20; i++) begin
      halt = 1'($urandom); is_mem = 1'($urandom); is_store = 1'($urandom);
      writes_rd = 1'($urandom); branch_taken = 1'($urandom);
      cyc(1'($urandom), VHalt, "halt_hold");
    end

    // Asynchronous reset in the middle of a load.
    do_reset();
    halt = 1'b0; is_mem = 1'b1; is_store = 1'b0; writes_rd = 1'b1; branch_taken = 1'b0;
    cyc(1'b1, VFetch, "rmem_fetch");
    cyc(1'b1, VDec, "rmem_decode");
    cyc(1'b1, VReg, "rmem_regread");
    cyc(1'b1, VAlu, "rmem_alu");
    cyc(1'b0, mem_vec(1'b0), "rmem_mem");
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_mem", act_vec(), VZero);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, VFetch, "rmem_restart_fetch");
    cyc(1'b1, VDec, "rmem_restart_decode");
    cyc(1'b1, VReg, "rmem_restart_regread");
    cyc(1'b1, VAlu, "rmem_restart_alu");
    cyc(1'b1, mem_vec(1'b0), "rmem_restart_mem");
    cyc(1'b1, wb_vec(1'b1, 2'b01), "rmem_restart_wb");

`ifdef CTRL_MEM_TIMEOUT_EN
    do_reset();
    is_mem = 1'b0; writes_rd = 1'b0;
    cyc(1'b1, VFetch, "to_fetch");
    repeat (Timeout - 1) cyc(1'b0, VFetch, "to_fetch_wait");
    cyc(1'b0, VFault, "to_fetch_fault");
    repeat (3) cyc(1'($urandom), VFault, "to_fault_hold");
    do_reset();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_cleared: got %b want 0", fault);
    end
    is_mem = 1'b1;
    cyc(1'b1, VFetch, "lim_fetch");
    repeat (Timeout - 1) cyc(1'b0, VFetch, "lim_fetch_wait");
    cyc(1'b1, VDec, "lim_ready_on_limit");
    cyc(1'b1, VReg, "lim_regread");
    cyc(1'b1, VAlu, "lim_alu");
    cyc(1'b1, mem_vec(1'b0), "lim_mem");
    repeat (Timeout - 1) cyc(1'b0, mem_vec(1'b0), "lim_mem_wait");
    cyc(1'b0, VFault, "lim_mem_fault");
`else
    do_reset();
    is_mem = 1'b0;
    cyc(1'b1, VFetch, "nto_fetch");
    repeat (12) cyc(1'b0, VFetch, "nto_wait_forever");
    cyc(1'b1, VDec, "nto_decode");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
